leb128_fetch: RTL

- Sequential LEB128 immediate decoder between the ROM and the core's decode stage.
- On `start` it reads bytes from the ROM port starting at a given address, one byte per cycle.
- It accumulates the varint and returns a 32- or 64-bit signed or unsigned value, the encoded length, and an error code.
- The core uses it for wasm immediates (`i32.const`, `i64.const`, local/func indices, block offsets).

---
 rtl/leb128_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/leb128_fetch.sv
// leb128_fetch: sequential LEB128 varint decoder reading one byte per cycle from a registered ROM
module leb128_fetch #(
  parameter int MEM_DEPTH = 6,
  parameter int MEM_EXTRA = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_DEPTH:0]        addr,
  input  logic                      is_signed,
  input  logic                      is64,
  output logic                      busy,
  output logic                      done,
  output logic [63:0]               value,
  output logic [3:0]                length,
  output logic [2:0]                error,
  output logic [MEM_DEPTH:0]        mem_addr,
  output logic [MEM_EXTRA-1:0]      mem_extra,
  input  logic [2**MEM_EXTRA*8-1:0] mem_data,
  input  logic                      mem_error
);
  localparam int AW = MEM_DEPTH + 1;
  localparam int AW1 = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, FINISH} state_t;
  state_t state;
  logic [AW-1:0] base;
  logic sgn, w64;
  logic [63:0] acc;
  logic [3:0] k;
  logic [7:0] b;
  logic [6:0] sh, shl;
  logic [3:0] kn, maxl;
  logic [63:0] acc_n, fill, full, res;
  logic last_slot, bad_final, wrap, fin;
  logic [AW:0] next_a;
  logic [2:0] err_n;
  logic unused_hi;
  assign mem_extra = '0;
  assign unused_hi = ^mem_data[2**MEM_EXTRA*8-1:8];
  always_comb begin
    b = mem_data[7:0];
    kn = k + 4'd1;
    sh = 7'(k) * 7'd7;
    shl = 7'(kn) * 7'd7;
    maxl = w64 ? 4'd10 : 4'd5;
    last_slot = kn == maxl;
    acc_n = acc | ({57'd0, b[6:0]} << sh);
    fill = (sgn && b[6] && shl < (w64 ? 7'd64 : 7'd32)) ? ~((64'd1 << shl) - 64'd1) : 64'd0;
    full = acc_n | fill;
    res = w64 ? full : {32'd0, full[31:0]};
    // Only the byte at the maximum length can carry bits beyond the target width
    bad_final = last_slot && (w64 ? (sgn ? !(b[6:0] == 7'h00 || b[6:0] == 7'h7f) : b[6:1] != 6'd0)
                                  : (sgn ? !(b[6:3] == 4'h0 || b[6:3] == 4'hf) : b[6:4] != 3'd0));
    next_a = {1'b0, base} + AW1'(kn);
    wrap = next_a[AW];
    err_n = mem_error ? 3'd1 : b[7] ? (last_slot ? 3'd2 : wrap ? 3'd4 : 3'd0) : (bad_final ? 3'd3 : 3'd0);
    fin = mem_error || !b[7] || last_slot || wrap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      value <= '0;
      length <= '0;
      error <= '0;
      mem_addr <= '0;
      base <= '0;
      sgn <= 1'b0;
      w64 <= 1'b0;
      acc <= '0;
      k <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base <= addr;
          sgn <= is_signed;
          w64 <= is64;
          acc <= '0;
          k <= '0;
          mem_addr <= addr;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          mem_addr <= mem_addr + 1'b1;
          state <= RUN;
        end
        RUN: begin
          acc <= acc_n;
          k <= kn;
          mem_addr <= mem_addr + 1'b1;
          if (fin) begin
            value <= res;
            length <= kn;
            error <= err_n;
            done <= 1'b1;
            state <= FINISH;
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
